// File: rtl/debug_pkg.sv
// Shared definitions for the debug bus arbiter: 3-bit state encodings and the
// default control-word width, also used by the monitor firmware model.
package debug_pkg;

    localparam int DEFAULT_CW_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_HALT_PEND = 3'd1,
        ST_STEPPING  = 3'd2,
        ST_HALTED    = 3'd3,
        ST_INJECT    = 3'd4,
        ST_RESUME    = 3'd5
    } state_t;

    // Microcode control logic must be tristated whenever the arbiter could own the bus.
    function automatic logic ctrl_tristated(state_t s);
        return (s == ST_HALTED) || (s == ST_INJECT) || (s == ST_RESUME);
    endfunction

    function automatic logic is_halted(state_t s);
        return (s == ST_HALTED) || (s == ST_INJECT);
    endfunction

endpackage

// File: rtl/halt_watchdog.sv
// Counts cycles spent waiting for an instruction boundary and flags when the
// halt has to be forced. HALT_TIMEOUT = 0 disables the watchdog.
module halt_watchdog #(
    parameter int HALT_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(HALT_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(HALT_TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturating counter: it must never wrap back into a non-expired value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (HALT_TIMEOUT != 0) && enable && (count_q == LIMIT);

endmodule

// File: rtl/debug_bus_arbiter.sv
// Run/halt/single-step arbiter for the shared control-word bus: microcode owns
// the bus while running, the debug host injects words while halted.
module debug_bus_arbiter
    import debug_pkg::*;
#(
    parameter int CW_WIDTH     = DEFAULT_CW_WIDTH,
    parameter int HALT_TIMEOUT = 16,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                instr_end,
    input  logic                dbg_halt,
    input  logic                dbg_step,
    input  logic                dbg_run,
    input  logic                dbg_cw_valid,
    input  logic [CW_WIDTH-1:0] dbg_cw,
    output logic                dbg_cw_ready,
    output logic                ctrlen,
    output logic [CW_WIDTH-1:0] cw_out,
    output logic                cw_oe,
    output logic                halted,
    output logic                halt_forced
);

    localparam state_t RESET_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;

    state_t              state_q, state_d;
    logic                step_q, step_d;
    logic                halt_forced_q, halt_forced_d;
    logic [CW_WIDTH-1:0] cw_out_q, cw_out_d;
    logic                ctrlen_q, ctrlen_d;
    logic                cw_oe_q, cw_oe_d;
    logic                halted_q, halted_d;
    logic                wd_enable;
    logic                wd_expired;

    assign wd_enable = (state_q == ST_HALT_PEND) || (state_q == ST_STEPPING);

    halt_watchdog #(
        .HALT_TIMEOUT(HALT_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (!wd_enable),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        halt_forced_d = halt_forced_q;
        cw_out_d      = cw_out_q;
        case (state_q)
            ST_RUN: begin
                if (dbg_halt) state_d = ST_HALT_PEND;
            end
            ST_HALT_PEND, ST_STEPPING: begin
                if (instr_end) begin
                    state_d = ST_HALTED;
                end else if (wd_expired) begin
                    state_d       = ST_HALTED;
                    halt_forced_d = 1'b1;
                end
            end
            ST_HALTED: begin
                // Inject beats step/run; a pulse arriving alongside it is dropped.
                if (dbg_cw_valid) begin
                    cw_out_d = dbg_cw;
                    state_d  = ST_INJECT;
                end else if (dbg_step) begin
                    step_d  = 1'b1;
                    state_d = ST_RESUME;
                end else if (dbg_run && !dbg_halt) begin
                    step_d  = 1'b0;
                    state_d = ST_RESUME;
                end
            end
            ST_INJECT: begin
                cw_out_d = '0;
                state_d  = ST_HALTED;
            end
            ST_RESUME: begin
                halt_forced_d = 1'b0;
                state_d       = step_q ? ST_STEPPING : ST_RUN;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // Registered outputs decode the next state so both enables switch on the same edge.
        ctrlen_d = ctrl_tristated(state_d);
        cw_oe_d  = (state_d == ST_INJECT);
        halted_d = is_halted(state_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= RESET_STATE;
            step_q        <= 1'b0;
            halt_forced_q <= 1'b0;
            cw_out_q      <= '0;
            ctrlen_q      <= RESET_HALTED;
            cw_oe_q       <= 1'b0;
            halted_q      <= RESET_HALTED;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            halt_forced_q <= halt_forced_d;
            cw_out_q      <= cw_out_d;
            ctrlen_q      <= ctrlen_d;
            cw_oe_q       <= cw_oe_d;
            halted_q      <= halted_d;
        end
    end

    assign dbg_cw_ready = (state_q == ST_HALTED);
    assign ctrlen       = ctrlen_q;
    assign cw_out       = cw_out_q;
    assign cw_oe        = cw_oe_q;
    assign halted       = halted_q;
    assign halt_forced  = halt_forced_q;

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Directed bench for debug_bus_arbiter with default parameters.
module tb_debug_bus_arbiter;

    // Status vector order: {halted, ctrlen, cw_oe, dbg_cw_ready, halt_forced}
    localparam logic [4:0] S_RUN     = 5'b00000;
    localparam logic [4:0] S_HALTED  = 5'b11010;
    localparam logic [4:0] S_INJECT  = 5'b11100;
    localparam logic [4:0] S_RESUME  = 5'b01000;
    localparam logic [4:0] S_FORCED  = 5'b00001;

    logic        clk;
    logic        rstn;
    logic        instr_end;
    logic        dbg_halt;
    logic        dbg_step;
    logic        dbg_run;
    logic        dbg_cw_valid;
    logic [31:0] dbg_cw;
    logic        dbg_cw_ready;
    logic        ctrlen;
    logic [31:0] cw_out;
    logic        cw_oe;
    logic        halted;
    logic        halt_forced;

    int tests;
    int failures;

    debug_bus_arbiter dut (
        .clk         (clk),
        .rstn        (rstn),
        .instr_end   (instr_end),
        .dbg_halt    (dbg_halt),
        .dbg_step    (dbg_step),
        .dbg_run     (dbg_run),
        .dbg_cw_valid(dbg_cw_valid),
        .dbg_cw      (dbg_cw),
        .dbg_cw_ready(dbg_cw_ready),
        .ctrlen      (ctrlen),
        .cw_out      (cw_out),
        .cw_oe       (cw_oe),
        .halted      (halted),
        .halt_forced (halt_forced)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input logic [4:0] expected);
        checkOutput(tag, {27'd0, halted, ctrlen, cw_oe, dbg_cw_ready, halt_forced}, {27'd0, expected});
    endtask

    task automatic checkInvariant(input string tag);
        checkOutput(tag, {31'd0, (ctrlen === 1'b0) && (cw_oe === 1'b1)}, 32'd0);
    endtask

    task automatic applyStimulus(input logic halt, input logic step, input logic run,
                                 input logic valid, input logic [31:0] cw, input logic iend);
        dbg_halt     = halt;
        dbg_step     = step;
        dbg_run      = run;
        dbg_cw_valid = valid;
        dbg_cw       = cw;
        instr_end    = iend;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkInvariant("bus_invariant");
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rstn     = 1'b0;
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        #1;
        checkStatus("reset_status", S_RUN);
        checkOutput("reset_cw_out", cw_out, 32'h0);
        tick();
        tick();
        checkStatus("reset_held", S_RUN);
        rstn = 1'b1;
        tick();
        checkStatus("run_after_reset", S_RUN);

        // RUN ignores step and run pulses
        applyStimulus(0, 1, 1, 0, 32'h0, 0);
        tick();
        checkStatus("run_ignores_step", S_RUN);

        // Test 1: halt request, instr_end three cycles later
        applyStimulus(1, 0, 0, 0, 32'h0, 0);
        tick();
        checkStatus("halt_pend_1", S_RUN);
        tick();
        tick();
        checkStatus("halt_pend_3", S_RUN);
        applyStimulus(1, 0, 0, 0, 32'h0, 1);
        tick();
        checkStatus("halted_at_boundary", S_HALTED);

        // dbg_run while dbg_halt is still high is ignored
        applyStimulus(1, 0, 1, 0, 32'h0, 0);
        tick();
        checkStatus("run_blocked_by_halt", S_HALTED);

        // Test 2: inject DEADBEEF
        applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        #1;
        checkOutput("ready_in_halted", {31'd0, dbg_cw_ready}, 32'd1);
        tick();
        checkStatus("inject_status", S_INJECT);
        checkOutput("inject_word", cw_out, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        tick();
        checkStatus("after_inject", S_HALTED);
        checkOutput("cw_out_cleared", cw_out, 32'h0);

        // Inject, step and run together: inject wins, pulses are lost
        applyStimulus(0, 1, 1, 1, 32'h1234_5678, 0);
        tick();
        checkStatus("inject_priority", S_INJECT);
        checkOutput("inject_priority_word", cw_out, 32'h1234_5678);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        tick();
        tick();
        checkStatus("pulses_lost", S_HALTED);

        // Test 3: single step
        applyStimulus(0, 1, 0, 0, 32'h0, 0);
        tick();
        checkStatus("step_resume", S_RESUME);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        tick();
        checkStatus("stepping_1", S_RUN);
        tick();
        checkStatus("stepping_2", S_RUN);
        applyStimulus(0, 0, 0, 0, 32'h0, 1);
        tick();
        checkStatus("step_done", S_HALTED);

        // Resume free running
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        tick();
        checkStatus("run_resume", S_RESUME);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        tick();
        checkStatus("running_again", S_RUN);

        // Test 4: halt and instr_end on the same edge, then watchdog
        applyStimulus(1, 0, 0, 0, 32'h0, 1);
        tick();
        checkStatus("no_mid_instr_halt", S_RUN);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 15; i++) tick();
        checkStatus("watchdog_not_yet", S_RUN);
        tick();
        checkStatus("watchdog_forced", S_HALTED | S_FORCED);
        applyStimulus(0, 0, 1, 0, 32'h0, 0);
        tick();
        checkStatus("forced_resume", S_RESUME | S_FORCED);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        tick();
        checkStatus("forced_cleared", S_RUN);

        // Test 5: reset in the middle of an inject
        applyStimulus(1, 0, 0, 0, 32'h0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 32'h0, 1);
        tick();
        checkStatus("halted_again", S_HALTED);
        applyStimulus(0, 0, 0, 1, 32'hA5A5_5A5A, 0);
        tick();
        checkStatus("inject_before_reset", S_INJECT);
        applyStimulus(0, 0, 0, 0, 32'h0, 0);
        #2;
        rstn = 1'b0;
        #1;
        checkStatus("async_reset_status", S_RUN);
        checkOutput("async_reset_cw_out", cw_out, 32'h0);
        checkInvariant("bus_invariant_reset");
        tick();
        rstn = 1'b1;
        tick();
        checkStatus("run_after_release", S_RUN);
        checkOutput("cw_out_after_release", cw_out, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
